sort_floats_n_bubble_fsm: RTL and testbench

//  Sorts N IEEE-754 floats ascending by bubble sort, one compare per cycle, via a shared external
//  f_less_or_equal unit. Parametrised successor of the 3-element FSM sorter: any N >= 2,

---
 rtl/float_sort_pkg.sv | 20 ++
 rtl/sort_floats_n_bubble_fsm_if.sv | 29 ++
 rtl/float_cswap.sv | 16 +
 rtl/sort_floats_n_bubble_fsm.sv | 171 +++++++++++++++++
 tb/tb_sort_floats_n_bubble_fsm.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/float_sort_pkg.sv
// Shared types and helpers for the bubble-sort float sorter.
// Holds the FSM state encoding, default sizes and the counter-width helper.
package float_sort_pkg;

  localparam int FLEN_DEFAULT = 64;
  localparam int N_DEFAULT    = 4;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CMP
  } state_e;

  // Width of the idx/pass counters; held at 1 so N < 2 still elaborates far enough to report.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [0:N_DEFAULT-1][FLEN_DEFAULT-1:0] flt_vec_t;

endpackage

// File: rtl/sort_floats_n_bubble_fsm_if.sv
// Bus between the sorter, its float producer/consumer and the shared f_less_or_equal unit.
// slave = sorter side, master = environment side (producer, consumer and comparator).
interface sort_floats_n_bubble_fsm_if #(
  parameter int FLEN = 64,
  parameter int N    = 4
);

  logic                      valid_in;
  logic [0:N-1][FLEN-1:0]    unsorted;
  logic                      valid_out;
  logic [0:N-1][FLEN-1:0]    sorted;
  logic                      err;
  logic                      busy;
  logic [FLEN-1:0]           f_le_a;
  logic [FLEN-1:0]           f_le_b;
  logic                      f_le_res;
  logic                      f_le_err;

  modport slave (
    input  valid_in, unsorted, f_le_res, f_le_err,
    output valid_out, sorted, err, busy, f_le_a, f_le_b
  );

  modport master (
    output valid_in, unsorted, f_le_res, f_le_err,
    input  valid_out, sorted, err, busy, f_le_a, f_le_b
  );

endinterface

// File: rtl/float_cswap.sv
// Combinational compare-exchange: orders a pair using the external a <= b verdict.
// Equal operands (le_i = 1) keep their order, which keeps the sort stable.
module float_cswap #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  input  logic            le_i,
  output logic [FLEN-1:0] lo_o,
  output logic [FLEN-1:0] hi_o
);

  assign lo_o = le_i ? a_i : b_i;
  assign hi_o = le_i ? b_i : a_i;

endmodule

// File: rtl/sort_floats_n_bubble_fsm.sv
// N-element ascending float bubble sorter, one compare per cycle through an external comparator.
// Define FLOAT_SORT_EARLY_EXIT_EN to stop after the first swap-free pass.
module sort_floats_n_bubble_fsm
  import float_sort_pkg::*;
#(
  parameter int FLEN = FLEN_DEFAULT,
  parameter int N    = N_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  sort_floats_n_bubble_fsm_if.slave    bus
);

  localparam int IW = idx_w(N);

  typedef logic [0:N-1][FLEN-1:0] vec_t;

  if (N < 2) begin : g_n_check
    $error("sort_floats_n_bubble_fsm: N must be at least 2");
  end

  state_e          state_q, state_d;
  vec_t            buf_q, buf_d;
  vec_t            sorted_q, sorted_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   pass_q, pass_d;
  logic            valid_out_q, valid_out_d;
  logic            err_q, err_d;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
  logic            swapped_q, swapped_d;
  logic            do_swap;
`endif

  logic [IW-1:0]   idx_nx;
  logic [FLEN-1:0] op_a, op_b;
  logic [FLEN-1:0] lo, hi;
  logic            last_cmp;
  logic            last_pass;
  logic            finish;

  assign idx_nx    = idx_q + IW'(1);
  assign op_a      = buf_q[idx_q];
  assign op_b      = buf_q[idx_nx];
  assign last_cmp  = (idx_q == (IW'(N - 2) - pass_q));
  assign last_pass = (pass_q == IW'(N - 2));

`ifdef FLOAT_SORT_EARLY_EXIT_EN
  assign do_swap = ~bus.f_le_res;
  // Current compare counts towards "this pass was swap-free".
  assign finish  = last_pass | ~(swapped_q | do_swap);
`else
  assign finish  = last_pass;
`endif

  float_cswap #(
    .FLEN (FLEN)
  ) u_cswap (
    .a_i  (op_a),
    .b_i  (op_b),
    .le_i (bus.f_le_res),
    .lo_o (lo),
    .hi_o (hi)
  );

  // NOTE: every variable gets its default before the case; a path that skips an
  // assignment would otherwise make synthesis infer a latch.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    sorted_d    = sorted_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    valid_out_d = 1'b0;
    err_d       = 1'b0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
    swapped_d   = swapped_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in) begin
          buf_d   = bus.unsorted;
          idx_d   = '0;
          pass_d  = '0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        if (bus.f_le_err) begin
          // Abort: hand back the buffer exactly as it stood before this compare.
          sorted_d    = buf_q;
          err_d       = 1'b1;
          valid_out_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          buf_d[idx_q]  = lo;
          buf_d[idx_nx] = hi;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
          swapped_d = swapped_q | do_swap;
`endif
          if (!last_cmp) begin
            idx_d = idx_nx;
          end else if (finish) begin
            sorted_d    = buf_d;
            valid_out_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            pass_d = pass_q + IW'(1);
            idx_d  = '0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      // NOTE: the element buffer is reset too, so a reset mid-sort leaves no stale
      // operands on f_le_a/f_le_b or in a later partial (err) result.
      buf_q       <= '0;
      sorted_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      valid_out_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
      swapped_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      sorted_q    <= sorted_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      valid_out_q <= valid_out_d;
      err_q       <= err_d;
`ifdef FLOAT_SORT_EARLY_EXIT_EN
      swapped_q   <= swapped_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_CMP);
  assign bus.valid_out = valid_out_q;
  assign bus.err       = err_q;
  assign bus.sorted    = sorted_q;
  assign bus.f_le_a    = (state_q == ST_CMP) ? op_a : '0;
  assign bus.f_le_b    = (state_q == ST_CMP) ? op_b : '0;

  a_valid_out_pulse : assert property (
    @(posedge clk) disable iff (!rst) valid_out_q |=> !valid_out_q
  );

  a_idx_bounded : assert property (
    @(posedge clk) disable iff (!rst)
      (state_q == ST_CMP) |-> (idx_q <= IW'(N - 2)) && (pass_q <= IW'(N - 2))
  );

endmodule

// File: tb/tb_sort_floats_n_bubble_fsm.sv
// Directed self-checking bench for sort_floats_n_bubble_fsm (FLEN=64, N=4) with a
// behavioural f_less_or_equal model that flags NaN operands.
module tb_sort_floats_n_bubble_fsm;
  import float_sort_pkg::*;

  localparam int FLEN = 64;
  localparam int N    = 4;

  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] FOUR  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] NEG1  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NZERO = 64'h8000_0000_0000_0000;

`ifdef FLOAT_SORT_EARLY_EXIT_EN
  localparam int SORTED_LAT  = 4;
  localparam int SORTED_CMPS = 3;
`else
  localparam int SORTED_LAT  = 7;
  localparam int SORTED_CMPS = 6;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_passed;
  int   swaps;
  int   cmps;

  sort_floats_n_bubble_fsm_if #(.FLEN(FLEN), .N(N)) bus ();

  sort_floats_n_bubble_fsm #(
    .FLEN (FLEN),
    .N    (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [63:0] x);
    return (&x[62:52]) && (|x[51:0]);
  endfunction

  // Comparator model: IEEE ordering via real compare, error on any NaN operand.
  always_comb begin
    bus.f_le_err = is_nan(bus.f_le_a) | is_nan(bus.f_le_b);
    bus.f_le_res = ($bitstoreal(bus.f_le_a) <= $bitstoreal(bus.f_le_b));
  end

  always @(posedge clk) begin
    if (rst && bus.busy) begin
      cmps <= cmps + 1;
      if (!bus.f_le_err && !bus.f_le_res) swaps <= swaps + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_valid_out(input int budget, inout int lat, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (bus.valid_out) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Launch one vector; lat counts edges from the capturing edge up to valid_out high.
  task automatic sort_one(input flt_vec_t v, output int lat, output logic timed_out,
                          output logic [63:0] a0, output logic [63:0] b0);
    @(posedge clk); #1;
    swaps = 0;
    cmps  = 0;
    bus.valid_in = 1'b1;
    bus.unsorted = v;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    a0  = bus.f_le_a;
    b0  = bus.f_le_b;
    lat = 1;
    wait_valid_out(100, lat, timed_out);
  endtask

  int          lat;
  logic        to;
  logic [63:0] a0, b0;
  int          seen;

  initial begin
    n_checks     = 0;
    n_passed     = 0;
    swaps        = 0;
    cmps         = 0;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    bus.unsorted = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_valid_out", bus.valid_out, 1'b0);
    check("rst_err",       bus.err,       1'b0);
    check("rst_sorted",    bus.sorted,    '0);
    check("rst_f_le_a",    bus.f_le_a,    '0);
    rst = 1'b1;

    // 1: reversed input, full bubble sort
    sort_one({FOUR, THREE, TWO, ONE}, lat, to, a0, b0);
    check("t1_timeout", to, 1'b0);
    check("t1_first_a", a0, FOUR);
    check("t1_first_b", b0, THREE);
    check("t1_sorted",  bus.sorted, {ONE, TWO, THREE, FOUR});
    check("t1_err",     bus.err, 1'b0);
    check("t1_busy",    bus.busy, 1'b0);
    check("t1_latency", lat, 7);
    check("t1_swaps",   swaps, 6);
    check("t1_cmps",    cmps, 6);
    @(posedge clk); #1;
    check("t1_pulse_end", bus.valid_out, 1'b0);
    check("t1_held",      bus.sorted, {ONE, TWO, THREE, FOUR});

    // 2: already sorted, early exit shortens the run when enabled
    sort_one({ONE, TWO, THREE, FOUR}, lat, to, a0, b0);
    check("t2_timeout", to, 1'b0);
    check("t2_sorted",  bus.sorted, {ONE, TWO, THREE, FOUR});
    check("t2_latency", lat, SORTED_LAT);
    check("t2_cmps",    cmps, SORTED_CMPS);
    check("t2_swaps",   swaps, 0);

    // 3: duplicates and a negative value
    sort_one({TWO, NEG1, TWO, ONE}, lat, to, a0, b0);
    check("t3_timeout", to, 1'b0);
    check("t3_sorted",  bus.sorted, {NEG1, ONE, TWO, TWO});
    check("t3_swaps",   swaps, 3);
    check("t3_latency", lat, 7);

    // 3b: +0.0 and -0.0 compare equal, so their input order must survive
    sort_one({PZERO, NZERO, ONE, NEG1}, lat, to, a0, b0);
    check("t3b_timeout", to, 1'b0);
    check("t3b_stable",  bus.sorted, {NEG1, PZERO, NZERO, ONE});

    // 4: NaN aborts on the first compare with the untouched buffer
    sort_one({ONE, QNAN, TWO, THREE}, lat, to, a0, b0);
    check("t4_timeout", to, 1'b0);
    check("t4_err",     bus.err, 1'b1);
    check("t4_busy",    bus.busy, 1'b0);
    check("t4_latency", lat, 2);
    check("t4_partial", bus.sorted, {ONE, QNAN, TWO, THREE});
    @(posedge clk); #1;
    check("t4_err_clr", bus.err, 1'b0);

    // 5: valid_in held while busy is ignored; next vector taken on the valid_out cycle
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.unsorted = {FOUR, THREE, TWO, ONE};
    @(posedge clk); #1;
    check("t5_busy_a", bus.busy, 1'b1);
    bus.unsorted = {NEG1, THREE, TWO, FOUR};
    lat = 1;
    wait_valid_out(100, lat, to);
    check("t5a_timeout", to, 1'b0);
    check("t5a_sorted",  bus.sorted, {ONE, TWO, THREE, FOUR});
    check("t5a_latency", lat, 7);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    check("t5_busy_b", bus.busy, 1'b1);
    lat = 1;
    wait_valid_out(100, lat, to);
    check("t5b_timeout", to, 1'b0);
    check("t5b_sorted",  bus.sorted, {NEG1, TWO, THREE, FOUR});

    // 6: reset two cycles into a sort aborts at once and never pulses afterwards
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.unsorted = {FOUR, THREE, TWO, ONE};
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_busy",      bus.busy, 1'b0);
    check("t6_valid_out", bus.valid_out, 1'b0);
    check("t6_sorted",    bus.sorted, '0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out || bus.busy) seen++;
    end
    check("t6_no_pulse", seen, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
